cellram_arbiter: RTL

Sequences all external CellRAM accesses and shares the single asynchronous CellRAM port between two requesters: the CPU data port, which serves load/store stalls, and the audio sample streamer, which is read-only. It sits between the controller/datapath memory select path and the board CellRAM pins. It generates chip-enable, output-enable and write-enable timing with a programmable wait-state count, and returns a one-cycle completion pulse to each requester. Round-robin arbitration keeps real-time audio reads from starving, and the CPU from being locked out.

---
 rtl/cellram_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/cellram_arbiter.sv
// cellram_arbiter: round-robin CPU/audio sharing of one asynchronous CellRAM port with
// programmable-wait strobe sequencing and one-cycle completion pulses.
module cellram_arbiter #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              aud_req,
  input  logic [ADDR_W-1:0] aud_addr,
  output logic [DATA_W-1:0] aud_rdata,
  output logic              aud_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dq_out,
  input  logic [DATA_W-1:0] mem_dq_in,
  output logic              mem_dq_oe,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, RECOVER} state_t;
  localparam logic [3:0] CNT_MAX = 4'(WAIT_CYC - 1);
  state_t state, state_nx;
  logic last_aud, gnt_aud, we_l, grant_aud, any_req, acc_end;
  logic [3:0] cnt;
  always_comb begin
    any_req   = cpu_req || aud_req;
    grant_aud = aud_req && (!cpu_req || !last_aud);
    acc_end   = state == ACCESS && cnt == CNT_MAX;
    state_nx  = state == IDLE   ? (any_req ? SETUP : IDLE) :
                state == SETUP  ? ACCESS :
                state == ACCESS ? (acc_end ? DONE : ACCESS) :
                state == DONE   ? RECOVER : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_aud   <= 1'b0;
      gnt_aud    <= 1'b0;
      we_l       <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_dq_out <= '0;
      cpu_rdata  <= '0;
      aud_rdata  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == ACCESS && !acc_end) ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && any_req) begin
        gnt_aud  <= grant_aud;
        last_aud <= grant_aud;
        we_l     <= !grant_aud && cpu_we;
        mem_addr <= grant_aud ? aud_addr : cpu_addr;
        if (!grant_aud) mem_dq_out <= cpu_wdata;
      end
      if (acc_end && !we_l && gnt_aud) aud_rdata <= mem_dq_in;
      if (acc_end && !we_l && !gnt_aud) cpu_rdata <= mem_dq_in;
    end
  end
  // Strobes decode from registered state only; no req-to-pin path.
  assign mem_ce_n  = !(state == SETUP || state == ACCESS);
  assign mem_oe_n  = !(state == ACCESS && !we_l);
  assign mem_we_n  = !(state == ACCESS && we_l);
  assign mem_dq_oe = we_l && (state == SETUP || state == ACCESS || state == DONE);
  assign cpu_ready = state == DONE && !gnt_aud;
  assign aud_ack   = state == DONE && gnt_aud;
  assign busy      = state != IDLE;
endmodule
